alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  - 32-bit integer ALU of the ARM execute (EXE) stage.
//  - Performs the operation selected by exec_cmd on val1/val2 (val2 is the shifter output).
//  - Produces the result plus NZCV flags. The status register and the memory stage consume both.
//  - Outputs are registered: exactly one clock of latency.
// PARAMETERS
//  WIDTH  32  datapath width; N = bit WIDTH-1, C = carry out of bit WIDTH-1
// PORTS
//  clk       in   1      rising-edge clock (single clock domain)
//  rst       in   1      asynchronous, active-high reset
//  val1      in   WIDTH  operand 1 (Rn)
//  val2      in   WIDTH  operand 2 (shifted/immediate operand)
//  exec_cmd  in   4      operation select (encodings below)
//  carry_in  in   1      current C flag, used by ADC/SBC
//  alu_res   out  WIDTH  registered result
//  status    out  4      registered flags {N,Z,C,V}; bit3=N, bit0=V
// BEHAVIOUR
//  - Reset: alu_res=0 and status=4'b0000 immediately on rst=1, held while rst=1.
//  - Each rising clk: compute from current inputs; register alu_res and status together.
//  - No handshake: every cycle is valid. Result of inputs at edge k is visible after edge k.
//  - exec_cmd encodings (shared package constants):
//      MOV=0001 res=val2           MVN=1001 res=~val2
//      ADD=0010 res=val1+val2      ADC=0011 res=val1+val2+carry_in
//      SUB=0100 res=val1-val2      SBC=0101 res=val1-val2-(~carry_in)
//      AND=0110 res=val1&val2      ORR=0111 res=val1|val2
//      EOR=1000 res=val1^val2
//  - Aliases share an encoding: CMP=SUB(0100), TST=AND(0110), LDR=STR=ADD(0010), for address computation.
//  - Any other code (0000, 1010-1111): alu_res=0, status=0000.
//  - Arithmetic: compute in WIDTH+1 bits. Result is the low WIDTH bits; wrap-around is silent.
//  - N = res[WIDTH-1]. Z = (res==0). Both apply to every valid op.
//  - C for ADD/ADC = carry out of the MSB.
//  - C for SUB/SBC = NOT borrow (ARM convention): val1 + ~val2 + 1 (SUB) or + carry_in (SBC), carry out.
//  - V for add = operand signs equal and result sign differs.
//  - V for subtract = operand signs differ and result sign differs from val1.
//  - For MOV/MVN/AND/ORR/EOR: C=0, V=0.
//  - carry_in is ignored by every op except ADC/SBC.
//  - Reset asserted mid-operation discards the in-flight result.
//  - First edge after release registers the then-current inputs.
// STRUCTURE
//  - Shared package (arm_defs): the exec_cmd encodings above and WIDTH.
//  - A single combinational sub-module alu_core (pure datapath: result + flags) is natural.
//  - The top level wraps alu_core with the output register and async reset.
// TESTING (val1=-12, val2=20, carry_in=1 unless stated; check values one clock after applying)
//  1 MOV->20; MVN->0xFFFFFFEB(-21); ADD->8; ADC->9;
//    SUB->-32; SBC->-32 (carry_in=1); AND->20; ORR->-12; EOR->-32 (0xFFFFFFE0).
//  2 Overflow: ADD, val1=val2=-2147483647 -> res=2, status=0011 (C=1, V=1).
//  3 Negative: ADD, val1=10, val2=-21 -> res=-11, status=1000.
//  4 Zero: ADD, val1=-10, val2=10 -> res=0, status=0110 (Z=1, C=1).
//    CMP val1=val2=5 -> status=0110.
//  5 Alias/invalid: CMP/TST/LDR/STR equal SUB/AND/ADD/ADD outputs; exec_cmd=0000 or 1111 -> res=0, status=0000.
//  6 Reset: assert rst between edges -> outputs 0 without a clock edge.
//    Release rst -> next edge shows the new result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the EXE-stage ALU: datapath width and the
// exec_cmd operation encodings. Aliases (CMP/TST/LDR/STR) share the
// encoding of the operation they reuse.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exec_cmd_e;

    localparam logic [3:0] CMD_CMP = CMD_SUB;
    localparam logic [3:0] CMD_TST = CMD_AND;
    localparam logic [3:0] CMD_LDR = CMD_ADD;
    localparam logic [3:0] CMD_STR = CMD_ADD;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the EXE-stage driver and the ALU.
//   master : drives val1, val2, exec_cmd, carry_in; observes alu_res, status
//   slave  : the ALU side (consumes operands, produces registered results)
interface alu_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [3:0]       exec_cmd;
    logic             carry_in;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       status;

    modport master (
        output val1, val2, exec_cmd, carry_in,
        input  alu_res, status
    );

    modport slave (
        input  val1, val2, exec_cmd, carry_in,
        output alu_res, status
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {N,Z,C,V} flags for exec_cmd.
//   val1, val2  operands (val2 = shifter output)
//   exec_cmd    operation select
//   carry_in    current C flag (ADC/SBC only)
//   res, flags  combinational result and {N,Z,C,V}
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [3:0]       exec_cmd,
    input  logic             carry_in,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend;
    logic             cin;
    logic             is_add;
    logic             is_sub;
    logic             valid;
    logic             c_flag;
    logic             v_flag;

    // Subtraction runs through the same adder as val1 + ~val2 + cin, so the
    // carry out is directly ARM's NOT-borrow.
    always_comb begin
        is_add = (exec_cmd == CMD_ADD) || (exec_cmd == CMD_ADC);
        is_sub = (exec_cmd == CMD_SUB) || (exec_cmd == CMD_SBC);
        addend = is_sub ? ~val2 : val2;
        case (exec_cmd)
            CMD_ADC: cin = carry_in;
            CMD_SUB: cin = 1'b1;
            CMD_SBC: cin = carry_in;
            default: cin = 1'b0;
        endcase
        sum = {1'b0, val1} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        res   = '0;
        valid = 1'b1;
        case (exec_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD,
            CMD_ADC,
            CMD_SUB,
            CMD_SBC: res = sum[WIDTH-1:0];
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
            default: valid = 1'b0;
        endcase
    end

    // Using the inverted addend makes the subtract overflow rule identical
    // to the add rule: operand signs equal, result sign differs.
    always_comb begin
        c_flag = (is_add || is_sub) && sum[WIDTH];
        v_flag = (is_add || is_sub)
                 && (val1[WIDTH-1] == addend[WIDTH-1])
                 && (res[WIDTH-1] != val1[WIDTH-1]);
        if (valid)
            flags = {res[WIDTH-1], (res == '0), c_flag, v_flag};
        else
            flags = 4'b0000;
    end

endmodule

// File: rtl/alu.sv
// EXE-stage ALU with registered outputs (one clock of latency).
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears alu_res and status
//   bus  alu_if.slave: val1, val2, exec_cmd, carry_in in; alu_res, status out
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flags;

    alu_core u_core (
        .val1     (bus.val1),
        .val2     (bus.val2),
        .exec_cmd (bus.exec_cmd),
        .carry_in (bus.carry_in),
        .res      (core_res),
        .flags    (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_res <= '0;
            bus.status  <= 4'b0000;
        end else begin
            bus.alu_res <= core_res;
            bus.status  <= core_flags;
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
        bus.exec_cmd = cmd;
        bus.val1     = a;
        bus.val2     = b;
        bus.carry_in = cin;
    endtask

    task automatic run(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic cin,
                       input logic [31:0] exp_res, input logic [3:0] exp_st);
        @(negedge clk);
        drive(cmd, a, b, cin);
        @(posedge clk);
        #1;
        check({tag, ".res"}, bus.alu_res, exp_res);
        check({tag, ".status"}, {28'd0, bus.status}, {28'd0, exp_st});
    endtask

    localparam logic [31:0] M12 = 32'hFFFF_FFF4;
    localparam logic [31:0] P20 = 32'd20;

    initial begin
        drive(CMD_ADD, M12, P20, 1'b1);
        #2;
        check("rst0.res", bus.alu_res, 32'd0);
        check("rst0.status", {28'd0, bus.status}, 32'd0);
        @(posedge clk);
        #1;
        check("rst1.res", bus.alu_res, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("MOV", CMD_MOV, M12, P20, 1'b1, 32'd20, 4'b0000);
        run("MVN", CMD_MVN, M12, P20, 1'b1, 32'hFFFF_FFEB, 4'b1000);
        run("ADD", CMD_ADD, M12, P20, 1'b1, 32'd8, 4'b0010);
        run("ADC", CMD_ADC, M12, P20, 1'b1, 32'd9, 4'b0010);
        run("SUB", CMD_SUB, M12, P20, 1'b1, 32'hFFFF_FFE0, 4'b1010);
        run("SBC", CMD_SBC, M12, P20, 1'b1, 32'hFFFF_FFE0, 4'b1010);
        run("AND", CMD_AND, M12, P20, 1'b1, 32'd20, 4'b0000);
        run("ORR", CMD_ORR, M12, P20, 1'b1, M12, 4'b1000);
        run("EOR", CMD_EOR, M12, P20, 1'b1, 32'hFFFF_FFE0, 4'b1000);

        run("ADC_c0", CMD_ADC, M12, P20, 1'b0, 32'd8, 4'b0010);
        run("SBC_c0", CMD_SBC, M12, P20, 1'b0, 32'hFFFF_FFDF, 4'b1010);
        run("MOV_c0", CMD_MOV, M12, P20, 1'b0, 32'd20, 4'b0000);
        run("ADD_c0", CMD_ADD, M12, P20, 1'b0, 32'd8, 4'b0010);
        run("SUB_c0", CMD_SUB, M12, P20, 1'b0, 32'hFFFF_FFE0, 4'b1010);

        run("ADD_ovf", CMD_ADD, 32'h8000_0001, 32'h8000_0001, 1'b1, 32'd2, 4'b0011);
        run("ADD_neg", CMD_ADD, 32'd10, 32'hFFFF_FFEB, 1'b1, 32'hFFFF_FFF5, 4'b1000);
        run("ADD_zero", CMD_ADD, 32'hFFFF_FFF6, 32'd10, 1'b1, 32'd0, 4'b0110);
        run("ADD_pos_ovf", CMD_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b1001);
        run("CMP_eq", CMD_CMP, 32'd5, 32'd5, 1'b1, 32'd0, 4'b0110);
        run("SUB_borrow", CMD_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1000);
        run("SUB_ovf", CMD_SUB, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 4'b0011);
        run("SBC_ovf", CMD_SBC, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 4'b1001);

        run("CMP", CMD_CMP, M12, P20, 1'b1, 32'hFFFF_FFE0, 4'b1010);
        run("TST", CMD_TST, M12, P20, 1'b1, 32'd20, 4'b0000);
        run("LDR", CMD_LDR, M12, P20, 1'b1, 32'd8, 4'b0010);
        run("STR", CMD_STR, M12, P20, 1'b1, 32'd8, 4'b0010);

        run("INV0_prep", CMD_MVN, M12, P20, 1'b1, 32'hFFFF_FFEB, 4'b1000);
        run("INV0000", 4'b0000, M12, P20, 1'b1, 32'd0, 4'b0000);
        run("INV_prep", CMD_MVN, M12, P20, 1'b1, 32'hFFFF_FFEB, 4'b1000);
        run("INV1010", 4'b1010, M12, P20, 1'b1, 32'd0, 4'b0000);
        run("INV_prep2", CMD_MVN, M12, P20, 1'b1, 32'hFFFF_FFEB, 4'b1000);
        run("INV1111", 4'b1111, M12, P20, 1'b1, 32'd0, 4'b0000);

        run("pre_rst", CMD_MVN, M12, P20, 1'b1, 32'hFFFF_FFEB, 4'b1000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst.res", bus.alu_res, 32'd0);
        check("async_rst.status", {28'd0, bus.status}, 32'd0);
        drive(CMD_ADD, 32'd10, 32'hFFFF_FFEB, 1'b1);
        @(posedge clk);
        #1;
        check("rst_held.res", bus.alu_res, 32'd0);
        check("rst_held.status", {28'd0, bus.status}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel.res", bus.alu_res, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst.res", bus.alu_res, 32'hFFFF_FFF5);
        check("post_rst.status", {28'd0, bus.status}, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
